cdr_loop_filter: RTL and testbench

//  Digital loop filter of the RX CDR. Consumes bang-bang early/late votes from the phase

---
 rtl/cdr_loop_filter.sv | 162 ++++++++++++++++
 tb/tb_cdr_loop_filter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cdr_loop_filter.sv
// RX CDR digital loop filter: decimates bang-bang PD votes into windows and steers the
// phase interpolator code through proportional + saturating integral paths, ACQ then TRACK gain.
module cdr_loop_filter #(
  parameter int CODE_W      = 9,
  parameter int FRAC_W      = 6,
  parameter int DECIM       = 8,
  parameter int KP_ACQ      = 4,
  parameter int KP_TRK      = 1,
  parameter int KI          = 2,
  parameter int FREQ_LIM    = 256,
  parameter int ACQ_WINDOWS = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              pd_valid,
  input  logic                              pd_early,
  input  logic                              pd_late,
  input  logic                              code_load,
  input  logic [CODE_W-1:0]                 code_init,
  output logic [CODE_W-1:0]                 phase_code,
  output logic                              code_valid,
  output logic signed [FRAC_W+CODE_W-3:0]   freq_acc,
  output logic                              locked
);

  localparam int ACC_W  = CODE_W + FRAC_W;
  localparam int FREQ_W = FRAC_W + CODE_W - 2;
  localparam int CNT_W  = $clog2(DECIM);
  localparam int SUM_W  = CNT_W + 2;
  localparam int ACQ_W  = $clog2(ACQ_WINDOWS + 1);

  localparam logic [CNT_W-1:0]         WIN_LAST = CNT_W'(DECIM - 1);
  localparam logic [ACQ_W-1:0]         ACQ_LAST = ACQ_W'(ACQ_WINDOWS - 1);
  localparam logic [ACC_W-1:0]         STEP_ACQ = ACC_W'(KP_ACQ * (2 ** FRAC_W));
  localparam logic [ACC_W-1:0]         STEP_TRK = ACC_W'(KP_TRK * (2 ** FRAC_W));
  localparam logic signed [FREQ_W:0]   KI_S     = (FREQ_W + 1)'(KI);
  localparam logic signed [FREQ_W:0]   LIM_P    = (FREQ_W + 1)'(FREQ_LIM);
  localparam logic signed [FREQ_W:0]   LIM_N    = -LIM_P;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2} state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          win_cnt;
  logic signed [SUM_W-1:0]   vote_sum;
  logic [ACQ_W-1:0]          acq_cnt;
  logic [ACC_W-1:0]          phase_acc;
  logic signed [1:0]         dir_p1;
  logic                      vld_p1;

  logic signed [1:0]         vote_p0;
  logic signed [SUM_W-1:0]   sum_next_p0;
  logic signed [1:0]         dir_next_p0;
  logic [ACC_W-1:0]          step_sel, pstep_p1, acc_next_p1;
  logic signed [FREQ_W:0]    ki_term_p1, freq_sum_p1;
  logic signed [FREQ_W-1:0]  freq_next_p1;

  function automatic logic signed [FREQ_W-1:0] sat_freq(input logic signed [FREQ_W:0] x);
    if (x > LIM_P)      return LIM_P[FREQ_W-1:0];
    else if (x < LIM_N) return LIM_N[FREQ_W-1:0];
    else                return x[FREQ_W-1:0];
  endfunction

  // stage p0: vote decode and window accumulation
  always_comb begin
    vote_p0 = 2'b00;
    if (pd_early && !pd_late)      vote_p0 = 2'b01;
    else if (pd_late && !pd_early) vote_p0 = 2'b11;
    sum_next_p0 = vote_sum + {{(SUM_W-2){vote_p0[1]}}, vote_p0};
    if (sum_next_p0[SUM_W-1])  dir_next_p0 = 2'b11;
    else if (|sum_next_p0)     dir_next_p0 = 2'b01;
    else                       dir_next_p0 = 2'b00;
  end

  // stage p1: proportional + integral update of the phase accumulator
  always_comb begin
    step_sel   = (state == TRACK) ? STEP_TRK : STEP_ACQ;
    pstep_p1   = '0;
    ki_term_p1 = '0;
    case (dir_p1)
      2'b01: begin pstep_p1 = step_sel;  ki_term_p1 = KI_S;  end
      2'b11: begin pstep_p1 = -step_sel; ki_term_p1 = -KI_S; end
      default: ;
    endcase
    freq_sum_p1  = {freq_acc[FREQ_W-1], freq_acc} + ki_term_p1;
    freq_next_p1 = sat_freq(freq_sum_p1);
    acc_next_p1  = phase_acc + pstep_p1
                 + {{(ACC_W-FREQ_W){freq_next_p1[FREQ_W-1]}}, freq_next_p1};
  end

  always_comb begin
    state_n = state;
    if (code_load)    state_n = enable ? ACQ : IDLE;
    else if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = ACQ;
        ACQ:     if (vld_p1 && acq_cnt == ACQ_LAST) state_n = TRACK;
        TRACK:   state_n = TRACK;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  assign locked = (state == TRACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt    <= '0;
      vote_sum   <= '0;
      dir_p1     <= '0;
      vld_p1     <= 1'b0;
      acq_cnt    <= '0;
      phase_acc  <= '0;
      phase_code <= '0;
      freq_acc   <= '0;
      code_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (code_load) begin
        phase_acc  <= {code_init, {FRAC_W{1'b0}}};
        phase_code <= code_init;
        freq_acc   <= '0;
        win_cnt    <= '0;
        vote_sum   <= '0;
        vld_p1     <= 1'b0;
        acq_cnt    <= '0;
      end else if (!enable) begin
        win_cnt  <= '0;
        vote_sum <= '0;
        vld_p1   <= 1'b0;
        acq_cnt  <= '0;
      end else begin
        vld_p1 <= 1'b0;
        if (pd_valid) begin
          if (win_cnt == WIN_LAST) begin
            win_cnt  <= '0;
            vote_sum <= '0;
            dir_p1   <= dir_next_p0;
            vld_p1   <= 1'b1;
          end else begin
            win_cnt  <= win_cnt + CNT_W'(1);
            vote_sum <= sum_next_p0;
          end
        end
        if (vld_p1) begin
          freq_acc   <= freq_next_p1;
          phase_acc  <= acc_next_p1;
          phase_code <= acc_next_p1[ACC_W-1 -: CODE_W];
          code_valid <= 1'b1;
          if (state == ACQ) acq_cnt <= acq_cnt + ACQ_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Scoreboard bench for cdr_loop_filter: window stimulus pushes expected (code, freq) pairs,
// a monitor pops one pair on every code_valid pulse.
module tb_cdr_loop_filter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, pd_valid, pd_early, pd_late, code_load;
  logic [8:0]        code_init;
  logic [8:0]        phase_code;
  logic              code_valid;
  logic signed [12:0] freq_acc;
  logic              locked;

  typedef struct {int code; int freq;} exp_t;
  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int m_acc, m_freq;

  cdr_loop_filter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pd_valid(pd_valid),
    .pd_early(pd_early), .pd_late(pd_late), .code_load(code_load),
    .code_init(code_init), .phase_code(phase_code), .code_valid(code_valid),
    .freq_acc(freq_acc), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // one vote per cycle; with gaps a pd_valid=0 cycle (early/late still set) follows each vote
  task automatic send(input int n, input bit e, input bit l, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pd_valid = 1'b1; pd_early = e; pd_late = l;
      if (gaps) begin
        @(posedge clk); #1;
        pd_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    pd_valid = 1'b0; pd_early = 1'b0; pd_late = 1'b0;
  endtask

  task automatic expect_upd(input int code, input int freq);
    exp_t x;
    x.code = code; x.freq = freq;
    exp_q.push_back(x);
  endtask

  task automatic load(input int code);
    @(posedge clk); #1;
    code_load = 1'b1; code_init = 9'(code);
    @(posedge clk); #1;
    code_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && code_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_code_valid", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("upd_phase_code", int'(phase_code), x.code);
        check("upd_freq_acc", int'(freq_acc), x.freq);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; pd_valid = 1'b0; pd_early = 1'b0; pd_late = 1'b0;
    code_load = 1'b0; code_init = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase_code", int'(phase_code), 0);
    check("rst_freq_acc", int'(freq_acc), 0);
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;

    // T1: disabled loop ignores votes
    send(32, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_phase_code", int'(phase_code), 0);
    check("t1_freq_acc", int'(freq_acc), 0);
    check("t1_locked", int'(locked), 0);

    // T2: ACQ steps, 2-clock latency
    enable = 1'b1;
    expect_upd(4, 2);
    send(8, 1'b1, 1'b0, 1'b0);
    check("t2_lat_valid_early", int'(code_valid), 0);
    check("t2_lat_code_early", int'(phase_code), 0);
    @(posedge clk); #1;
    check("t2_lat_valid", int'(code_valid), 1);
    check("t2_lat_code", int'(phase_code), 4);
    expect_upd(8, 4);
    send(8, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // T3: load near top, wrap 511 -> 0
    load(510);
    check("t3_load_code", int'(phase_code), 510);
    check("t3_load_freq", int'(freq_acc), 0);
    check("t3_load_valid", int'(code_valid), 0);
    expect_upd(2, 2);
    send(8, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // T4: tied windows give dir 0; invalid cycles are not counted
    expect_upd(2, 2);
    send(4, 1'b1, 1'b0, 1'b0);
    send(4, 1'b0, 1'b1, 1'b0);
    expect_upd(2, 2);
    send(8, 1'b1, 1'b1, 1'b0);
    expect_upd(6, 4);
    send(8, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);

    // T5: ACQ -> TRACK and integral saturation, from a clean preset
    load(0);
    m_acc = 0; m_freq = 0;
    for (int w = 1; w <= 132; w++) begin
      m_freq = (m_freq + 2 > 256) ? 256 : m_freq + 2;
      m_acc  = (m_acc + ((w <= 64) ? 4 : 1) * 64 + m_freq) % 32768;
      expect_upd(m_acc / 64, m_freq);
      send(8, 1'b1, 1'b0, 1'b0);
      if (w == 63 || w == 64) begin
        @(posedge clk); #1;
        check((w == 64) ? "t5_locked_64" : "t5_locked_63", int'(locked), (w == 64) ? 1 : 0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("t5_final_code", int'(phase_code), 86);
    check("t5_final_freq", int'(freq_acc), 256);
    check("t5_final_locked", int'(locked), 1);

    // T6: partial window discarded on enable drop, re-acquire with KP_ACQ
    send(5, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_hold_code", int'(phase_code), 86);
    check("t6_hold_freq", int'(freq_acc), 256);
    check("t6_idle_locked", int'(locked), 0);
    enable = 1'b1;
    expect_upd(85, 254);
    send(8, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_reacq_locked", int'(locked), 0);
    check("pending_updates", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
